// File: rtl/cam_pkg.sv
// Shared definitions for the camera capture path and the VGA scan-out side.
// Holds the frame geometry, the frame buffer address width, the capture
// state encoding and the RGB444 word layout stored in the frame buffer.
package cam_pkg;

  localparam int H_PIXELS     = 320;
  localparam int V_LINES      = 240;
  localparam int FRAME_PIXELS = H_PIXELS * V_LINES;
  localparam int ADDR_W       = 17;

  typedef enum logic [1:0] {
    IDLE,
    ARM,
    CAPTURE
  } cap_state_t;

  // Frame buffer word: top nibble unused, then R, G, B.
  typedef struct packed {
    logic [3:0] pad;
    logic [3:0] r;
    logic [3:0] g;
    logic [3:0] b;
  } rgb444_t;

  // hi carries R (low nibble of the first camera byte); lo is the second
  // byte, {G, B}.
  function automatic rgb444_t pack_rgb444(input logic [3:0] hi, input logic [7:0] lo);
    rgb444_t px;
    px.pad = 4'h0;
    px.r   = hi;
    px.g   = lo[7:4];
    px.b   = lo[3:0];
    return px;
  endfunction

endpackage

// File: rtl/ov7670_capture_if.sv
// Frame buffer write bus plus per-frame status.
//   frame_addr  : write address
//   frame_pixel : write data, RGB444 layout
//   frame_we    : write strobe, one cycle per pixel
//   frame_done  : one-cycle pulse at end of a captured frame
//   frame_err   : valid with frame_done, held until the next one
// master = capture side, slave = frame buffer / status consumer.
interface ov7670_capture_if #(
  parameter int ADDR_W = 17
);

  logic [ADDR_W-1:0] frame_addr;
  cam_pkg::rgb444_t  frame_pixel;
  logic              frame_we;
  logic              frame_done;
  logic              frame_err;

  modport master (
    output frame_addr,
    output frame_pixel,
    output frame_we,
    output frame_done,
    output frame_err
  );

  modport slave (
    input frame_addr,
    input frame_pixel,
    input frame_we,
    input frame_done,
    input frame_err
  );

endinterface

// File: rtl/cam_input_sync.sv
// Registers the OV7670 parallel bus once and detects vsync edges.
//   pclk, resetn        : clock, async active-low reset
//   cam_vsync/href/d    : raw camera pins
//   vs1, hr1, d1        : pins registered once
//   fs                  : registered pulse, vsync fell (frame start)
//   fe                  : registered pulse, vsync rose (frame end)
module cam_input_sync (
  input  logic       pclk,
  input  logic       resetn,
  input  logic       cam_vsync,
  input  logic       cam_href,
  input  logic [7:0] cam_d,
  output logic       vs1,
  output logic       hr1,
  output logic [7:0] d1,
  output logic       fs,
  output logic       fe
);

  logic vs2;

  always_ff @(posedge pclk or negedge resetn) begin
    if (!resetn) begin
      vs1 <= 1'b0;
      vs2 <= 1'b0;
      hr1 <= 1'b0;
      d1  <= 8'h00;
      fs  <= 1'b0;
      fe  <= 1'b0;
    end else begin
      vs1 <= cam_vsync;
      vs2 <= vs1;
      hr1 <= cam_href;
      d1  <= cam_d;
      fs  <= vs2 & ~vs1;
      fe  <= ~vs2 & vs1;
    end
  end

endmodule

// File: rtl/ov7670_capture.sv
// OV7670 RGB444 capture into a linear QVGA frame buffer.
//   pclk, resetn   : camera pixel clock, async active-low reset
//   cam_vsync/href : camera sync pins
//   cam_d          : camera data bus
//   capture_en     : capture whole frames while high
//   fb             : frame buffer write bus and frame status (master)
//   capturing      : high while in CAPTURE
//
// state   | meaning
// IDLE    | capture disabled
// ARM     | enabled, waiting for the next frame start
// CAPTURE | assembling pixels of the current frame until frame end
module ov7670_capture #(
  parameter int H_PIXELS = cam_pkg::H_PIXELS,
  parameter int V_LINES  = cam_pkg::V_LINES,
  parameter int ADDR_W   = cam_pkg::ADDR_W
) (
  input  logic                      pclk,
  input  logic                      resetn,
  input  logic                      cam_vsync,
  input  logic                      cam_href,
  input  logic [7:0]                cam_d,
  input  logic                      capture_en,
  ov7670_capture_if.master          fb,
  output logic                      capturing
);

  import cam_pkg::cap_state_t, cam_pkg::IDLE, cam_pkg::ARM, cam_pkg::CAPTURE;
  import cam_pkg::rgb444_t, cam_pkg::pack_rgb444;

  localparam int                FRAME_N   = H_PIXELS * V_LINES;
  localparam logic [ADDR_W-1:0] FRAME_END = ADDR_W'(FRAME_N);

  logic       vs1, hr1, fs, fe;
  logic [7:0] d1;

  cam_input_sync u_sync (
    .pclk      (pclk),
    .resetn    (resetn),
    .cam_vsync (cam_vsync),
    .cam_href  (cam_href),
    .cam_d     (cam_d),
    .vs1       (vs1),
    .hr1       (hr1),
    .d1        (d1),
    .fs        (fs),
    .fe        (fe)
  );

  cap_state_t        state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              phase_q, phase_d;
  logic [3:0]        hi_q, hi_d;
  logic              err_q, err_d;
  logic [ADDR_W-1:0] waddr_q, waddr_d;
  rgb444_t           wpix_q, wpix_d;
  logic              we_q, we_d;
  logic              done_q, done_d;
  logic              ferr_q, ferr_d;

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    phase_d = phase_q;
    hi_d    = hi_q;
    err_d   = err_q;
    waddr_d = waddr_q;
    wpix_d  = wpix_q;
    we_d    = 1'b0;
    done_d  = 1'b0;
    ferr_d  = ferr_q;

    case (state_q)
      IDLE: begin
        if (capture_en) state_d = ARM;
      end

      ARM: begin
        if (!capture_en) begin
          state_d = IDLE;
        end else if (fs) begin
          state_d = CAPTURE;
          addr_d  = '0;
          phase_d = 1'b0;
          err_d   = 1'b0;
        end
      end

      CAPTURE: begin
        if (!vs1) begin
          if (hr1) begin
            if (!phase_q) begin
              hi_d    = d1[3:0];
              phase_d = 1'b1;
            end else begin
              phase_d = 1'b0;
              if (addr_q == FRAME_END) begin
                err_d = 1'b1;
              end else begin
                we_d    = 1'b1;
                waddr_d = addr_q;
                wpix_d  = pack_rgb444(hi_q, d1);
                addr_d  = addr_q + 1'b1;
              end
            end
          end else if (phase_q) begin
            // line ended on an unpaired byte
            phase_d = 1'b0;
            err_d   = 1'b1;
          end
        end
        // addr_d/err_d already include a pixel completing this cycle
        if (fe) begin
          done_d  = 1'b1;
          ferr_d  = err_d | (addr_d != FRAME_END);
          state_d = capture_en ? ARM : IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge pclk or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      addr_q  <= '0;
      phase_q <= 1'b0;
      hi_q    <= 4'h0;
      err_q   <= 1'b0;
      waddr_q <= '0;
      wpix_q  <= '0;
      we_q    <= 1'b0;
      done_q  <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      phase_q <= phase_d;
      hi_q    <= hi_d;
      err_q   <= err_d;
      waddr_q <= waddr_d;
      wpix_q  <= wpix_d;
      we_q    <= we_d;
      done_q  <= done_d;
      ferr_q  <= ferr_d;
    end
  end

  assign fb.frame_addr  = waddr_q;
  assign fb.frame_pixel = wpix_q;
  assign fb.frame_we    = we_q;
  assign fb.frame_done  = done_q;
  assign fb.frame_err   = ferr_q;
  assign capturing      = (state_q == CAPTURE);

endmodule

// File: tb/tb_ov7670_capture.sv
// Bench for ov7670_capture on a reduced 8x4 frame (32 pixels). Expected
// writes per frame are derived from the byte stream of whole lines and
// compared on every write; frame status is compared on every frame_done.
module tb_ov7670_capture;

  localparam int H     = 8;
  localparam int V     = 4;
  localparam int FRAME = H * V;
  localparam int AW    = 17;

  logic       pclk;
  logic       resetn;
  logic       cam_vsync;
  logic       cam_href;
  logic [7:0] cam_d;
  logic       capture_en;
  logic       capturing;

  ov7670_capture_if #(.ADDR_W(AW)) fb ();

  ov7670_capture #(
    .H_PIXELS (H),
    .V_LINES  (V),
    .ADDR_W   (AW)
  ) dut (
    .pclk       (pclk),
    .resetn     (resetn),
    .cam_vsync  (cam_vsync),
    .cam_href   (cam_href),
    .cam_d      (cam_d),
    .capture_en (capture_en),
    .fb         (fb),
    .capturing  (capturing)
  );

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  int          vectors = 0;
  int          miscompares = 0;
  int          exp_addr[$];
  logic [15:0] exp_pix[$];
  logic        exp_err = 1'b0;
  int          we_total = 0;
  int          done_cnt = 0;
  int          last_addr = 0;
  logic [15:0] last_pix = '0;
  logic        prev_we = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] byte_of(input int l, input int i, input int mode);
    if (mode == 0) return (i % 2 == 0) ? 8'h0A : 8'hBC;
    return 8'((l * 37 + i * 11 + 5) & 255);
  endfunction

  // Expected pixels of one line: pair bytes in order, R from the low nibble
  // of the first byte, G/B from the second; never more than FRAME per frame.
  task automatic push_line(input int l, input int npix, input int mode,
                           inout int pix, inout logic e);
    logic [7:0] b0, b1;
    for (int p = 0; p < npix; p++) begin
      b0 = byte_of(l, 2 * p, mode);
      b1 = byte_of(l, 2 * p + 1, mode);
      if (pix < FRAME) begin
        exp_addr.push_back(pix);
        exp_pix.push_back({4'h0, b0[3:0], b1});
        pix++;
      end else begin
        e = 1'b1;
      end
    end
  endtask

  task automatic build(input int nlines, input int odd_line, input int mode, output int n);
    int   pix = 0;
    logic e = 1'b0;
    int   len;
    for (int l = 0; l < nlines; l++) begin
      len = 2 * H + ((l == odd_line) ? 1 : 0);
      if (len % 2 != 0) e = 1'b1;
      push_line(l, len / 2, mode, pix, e);
    end
    n = pix;
    exp_err = e | (pix != FRAME);
  endtask

  // Checker: every sampled cycle outside reset.
  always @(negedge pclk) begin
    if (resetn) begin
      check("we_spacing", int'(prev_we & fb.frame_we), 0);
      if (fb.frame_we) begin
        we_total++;
        last_addr = int'(fb.frame_addr);
        last_pix  = fb.frame_pixel;
        check("write_expected", int'(exp_addr.size() > 0), 1);
        if (exp_addr.size() > 0) begin
          check("frame_addr", int'(fb.frame_addr), exp_addr.pop_front());
          check("frame_pixel", int'(fb.frame_pixel), int'(exp_pix.pop_front()));
        end
      end
      if (fb.frame_done) begin
        done_cnt++;
        check("frame_err", int'(fb.frame_err), int'(exp_err));
      end
      prev_we = fb.frame_we;
    end else begin
      prev_we = 1'b0;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge pclk);
  endtask

  task automatic frame_open();
    @(negedge pclk) cam_vsync = 1'b1;
    tick(4);
    @(negedge pclk) cam_vsync = 1'b0;
    tick(6);
  endtask

  task automatic send_line(input int l, input int len, input int mode);
    for (int i = 0; i < len; i++) begin
      @(negedge pclk);
      cam_href = 1'b1;
      cam_d    = byte_of(l, i, mode);
    end
    @(negedge pclk);
    cam_href = 1'b0;
    cam_d    = 8'h00;
    tick(3);
  endtask

  task automatic send_frame(input int nlines, input int odd_line, input int mode,
                            input int drop_line);
    frame_open();
    for (int l = 0; l < nlines; l++) begin
      if (l == drop_line) capture_en = 1'b0;
      send_line(l, 2 * H + ((l == odd_line) ? 1 : 0), mode);
    end
    @(negedge pclk) cam_vsync = 1'b1;
    tick(10);
  endtask

  task automatic run_frame(input string tag, input int nlines, input int odd_line,
                           input int mode, input int drop_line);
    int n, w0, d0;
    build(nlines, odd_line, mode, n);
    w0 = we_total;
    d0 = done_cnt;
    send_frame(nlines, odd_line, mode, drop_line);
    check({tag, "_done"}, done_cnt - d0, 1);
    check({tag, "_writes"}, we_total - w0, n);
    check({tag, "_left"}, exp_addr.size(), 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int w0, d0, n;
    logic e;
    resetn     = 1'b0;
    cam_vsync  = 1'b1;
    cam_href   = 1'b0;
    cam_d      = 8'h00;
    capture_en = 1'b1;
    tick(2);
    check("rst_addr", int'(fb.frame_addr), 0);
    check("rst_pixel", int'(fb.frame_pixel), 0);
    check("rst_ctl", int'({fb.frame_we, fb.frame_done, fb.frame_err, capturing}), 0);
    @(negedge pclk) resetn = 1'b1;
    tick(3);

    // full frame, constant pixel 0x0ABC
    w0 = we_total;
    run_frame("full", V, -1, 0, -1);
    check("full_lit_writes", we_total - w0, 32);
    check("full_lit_last_addr", last_addr, 31);
    check("full_lit_last_pix", int'(last_pix), 'h0ABC);
    check("full_lit_err", int'(fb.frame_err), 0);

    // latency: single pixel, exact cycle placement of write and done
    frame_open();
    exp_addr.push_back(0);
    exp_pix.push_back(16'h056F);
    exp_err = 1'b1;
    d0 = done_cnt;
    @(negedge pclk); cam_href = 1'b1; cam_d = 8'h05;
    @(negedge pclk); cam_d = 8'h6F;
    @(negedge pclk); cam_href = 1'b0; cam_d = 8'h00;
    check("lat_we_k", int'(fb.frame_we), 0);
    @(negedge pclk);
    check("lat_we_k1", int'(fb.frame_we), 1);
    check("lat_pix_k1", int'(fb.frame_pixel), 'h056F);
    check("lat_addr_k1", int'(fb.frame_addr), 0);
    @(negedge pclk);
    check("lat_we_k2", int'(fb.frame_we), 0);
    tick(3);
    @(negedge pclk) cam_vsync = 1'b1;
    @(negedge pclk);
    @(negedge pclk);
    check("lat_done_k1", int'(fb.frame_done), 0);
    @(negedge pclk);
    check("lat_done_k2", int'(fb.frame_done), 1);
    check("lat_err_k2", int'(fb.frame_err), 1);
    @(negedge pclk);
    check("lat_done_k3", int'(fb.frame_done), 0);
    check("lat_err_hold", int'(fb.frame_err), 1);
    check("lat_done_cnt", done_cnt - d0, 1);
    tick(5);

    // short frame: one line missing
    run_frame("short", V - 1, -1, 1, -1);
    check("short_lit_last_addr", last_addr, 23);
    check("short_lit_err", int'(fb.frame_err), 1);

    // odd byte on line 1; line 2 must still pair correctly
    run_frame("odd", V, 1, 1, -1);
    check("odd_lit_err", int'(fb.frame_err), 1);

    // overflow: one extra line
    w0 = we_total;
    run_frame("ovf", V + 1, -1, 1, -1);
    check("ovf_lit_writes", we_total - w0, 32);
    check("ovf_lit_last_addr", last_addr, 31);
    check("ovf_lit_err", int'(fb.frame_err), 1);

    // capture_en dropped mid-frame: frame completes, then nothing
    run_frame("drop", V, -1, 1, 2);
    check("drop_lit_err", int'(fb.frame_err), 0);
    check("drop_capturing", int'(capturing), 0);
    w0 = we_total;
    d0 = done_cnt;
    send_frame(V, -1, 0, -1);
    check("off_writes", we_total - w0, 0);
    check("off_done", done_cnt - d0, 0);

    // reset in the middle of line 2
    capture_en = 1'b1;
    tick(3);
    frame_open();
    n = 0;
    e = 1'b0;
    push_line(0, H, 1, n, e);
    push_line(1, H, 1, n, e);
    push_line(2, 2, 1, n, e);
    w0 = we_total;
    d0 = done_cnt;
    send_line(0, 2 * H, 1);
    send_line(1, 2 * H, 1);
    for (int i = 0; i < 5; i++) begin
      @(negedge pclk);
      cam_href = 1'b1;
      cam_d    = byte_of(2, i, 1);
    end
    @(negedge pclk);
    #2 resetn = 1'b0;
    #1;
    check("rst_mid_addr", int'(fb.frame_addr), 0);
    check("rst_mid_pixel", int'(fb.frame_pixel), 0);
    check("rst_mid_ctl", int'({fb.frame_we, fb.frame_done, fb.frame_err, capturing}), 0);
    check("rst_pre_writes", we_total - w0, 18);
    exp_addr.delete();
    exp_pix.delete();
    @(negedge pclk); cam_href = 1'b0; cam_d = 8'h00;
    tick(2);
    @(negedge pclk) resetn = 1'b1;
    send_line(3, 2 * H, 1);
    @(negedge pclk) cam_vsync = 1'b1;
    tick(10);
    check("rst_post_writes", we_total - w0, 18);
    check("rst_post_done", done_cnt - d0, 0);
    check("rst_post_capturing", int'(capturing), 0);

    // capture resumes at the next frame start
    run_frame("resume", V, -1, 1, -1);
    check("resume_lit_err", int'(fb.frame_err), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
